// File: rtl/vend_credit_fsm_pkg.sv
// -----------------------------------------------------------------------------
// vend_credit_fsm_pkg
// Shared definitions for the coin-credit vending controller:
//   - state_e        : controller state encoding (IDLE/COLLECT/VEND/CHANGE)
//   - DEF_*          : default coin values, price, credit limit and widths
//   - state_is_busy(): states in which coins are refused
// No ports; imported by vend_credit_acc and vend_credit_fsm.
// -----------------------------------------------------------------------------
package vend_credit_fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // credit == 0
        ST_COLLECT = 2'd1,  // 0 < credit < PRICE
        ST_VEND    = 2'd2,  // water pulse this cycle
        ST_CHANGE  = 2'd3   // one change pulse this cycle
    } state_e;

    localparam int unsigned DEF_CREDIT_W   = 5;
    localparam int unsigned DEF_CNT_W      = 8;
    localparam int unsigned DEF_PRICE      = 3;
    localparam int unsigned DEF_MAX_CREDIT = 20;
    localparam int unsigned DEF_VAL_ONE    = 1;
    localparam int unsigned DEF_VAL_TWO    = 2;
    localparam int unsigned DEF_VAL_FIVE   = 5;

    function automatic logic state_is_busy(input state_e s);
        return (s == ST_VEND) || (s == ST_CHANGE);
    endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// -----------------------------------------------------------------------------
// vend_credit_acc
// Credit accumulator: owns the credit register, coin priority selection,
// over-credit check and the registered coin_reject pulse.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_one/two/five  : coin pulses (priority FIVE > TWO > ONE)
//   i_coin_en       : controller is able to take a coin this cycle
//   i_sub_price     : subtract PRICE this cycle (vend)
//   i_dec           : subtract one unit this cycle (change/refund pulse)
//   o_credit        : current credit
//   o_sum           : credit + selected coin value, one bit wider than credit
//   o_accept        : selected coin is accepted this cycle
//   o_coin_reject   : registered pulse, some presented coin was not accepted
// -----------------------------------------------------------------------------
module vend_credit_acc
    import vend_credit_fsm_pkg::*;
#(
    parameter int unsigned CREDIT_W   = DEF_CREDIT_W,
    parameter int unsigned PRICE      = DEF_PRICE,
    parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT,
    parameter int unsigned VAL_ONE    = DEF_VAL_ONE,
    parameter int unsigned VAL_TWO    = DEF_VAL_TWO,
    parameter int unsigned VAL_FIVE   = DEF_VAL_FIVE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_one,
    input  logic                i_two,
    input  logic                i_five,
    input  logic                i_coin_en,
    input  logic                i_sub_price,
    input  logic                i_dec,
    output logic [CREDIT_W-1:0] o_credit,
    output logic [CREDIT_W:0]   o_sum,
    output logic                o_accept,
    output logic                o_coin_reject
);

    // Coin values and limit at CREDIT_W+1 bits so the sum can never wrap.
    localparam logic [CREDIT_W:0]   LP_ONE   = (CREDIT_W + 1)'(VAL_ONE);
    localparam logic [CREDIT_W:0]   LP_TWO   = (CREDIT_W + 1)'(VAL_TWO);
    localparam logic [CREDIT_W:0]   LP_FIVE  = (CREDIT_W + 1)'(VAL_FIVE);
    localparam logic [CREDIT_W:0]   LP_MAX   = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] LP_PRICE = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] LP_UNIT  = CREDIT_W'(1);

    logic [CREDIT_W-1:0] r_credit;
    logic                r_coin_reject;

    logic [CREDIT_W:0]   w_val;
    logic [CREDIT_W:0]   w_sum;
    logic                w_any;
    logic                w_multi;
    logic                w_fits;
    logic                w_accept;
    logic                w_reject;
    logic [CREDIT_W-1:0] w_base;
    logic [CREDIT_W-1:0] w_next;

    // NOTE: every signal gets a default before the priority chain; without it
    // a path that skips the assignment would infer a latch.
    always_comb begin
        w_val = '0;
        w_any = 1'b0;
        if (i_five) begin
            w_val = LP_FIVE;
            w_any = 1'b1;
        end else if (i_two) begin
            w_val = LP_TWO;
            w_any = 1'b1;
        end else if (i_one) begin
            w_val = LP_ONE;
            w_any = 1'b1;
        end
    end

    assign w_sum    = {1'b0, r_credit} + w_val;
    assign w_fits   = (w_sum <= LP_MAX);
    assign w_accept = i_coin_en & w_any & w_fits;
    assign w_multi  = (i_five & i_two) | (i_five & i_one) | (i_two & i_one);

    // Accepted: only the lower-priority extras are refused. Not accepted:
    // everything presented is refused.
    assign w_reject = w_accept ? w_multi : w_any;

    // w_fits guarantees the top bit of w_sum is clear when a coin is taken.
    assign w_base = w_accept ? w_sum[CREDIT_W-1:0] : r_credit;
    assign w_next = w_base - (i_sub_price ? LP_PRICE : '0) - (i_dec ? LP_UNIT : '0);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit      <= '0;
            r_coin_reject <= 1'b0;
        end else begin
            r_credit      <= w_next;
            r_coin_reject <= w_reject;
        end
    end

    assign o_credit      = r_credit;
    assign o_sum         = w_sum;
    assign o_accept      = w_accept;
    assign o_coin_reject = r_coin_reject;

endmodule

// File: rtl/vend_credit_fsm.sv
// -----------------------------------------------------------------------------
// vend_credit_fsm
// Coin-credit vending controller. Accumulates credit from three coin inputs,
// vends one item once credit reaches PRICE, then pays out any surplus as
// one-unit change pulses. Supports cancel/refund while collecting, rejects
// coins while busy or when they would exceed MAX_CREDIT, and keeps a
// saturating sales count.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   ONE, TWO, FIVE    : single-cycle coin pulses
//   cancel            : single-cycle refund request (honoured in COLLECT)
//   water             : one-cycle vend pulse
//   change            : one pulse per unit of change/refund
//   coin_reject       : one-cycle pulse, a presented coin was not accepted
//   busy              : high in VEND and CHANGE
//   credit            : current credit in units
//   sales             : items vended since reset, saturating
// -----------------------------------------------------------------------------
module vend_credit_fsm
    import vend_credit_fsm_pkg::*;
#(
    parameter int unsigned CREDIT_W   = DEF_CREDIT_W,
    parameter int unsigned PRICE      = DEF_PRICE,
    parameter int unsigned MAX_CREDIT = DEF_MAX_CREDIT,
    parameter int unsigned VAL_ONE    = DEF_VAL_ONE,
    parameter int unsigned VAL_TWO    = DEF_VAL_TWO,
    parameter int unsigned VAL_FIVE   = DEF_VAL_FIVE,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ONE,
    input  logic                TWO,
    input  logic                FIVE,
    input  logic                cancel,
    output logic                water,
    output logic                change,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [CNT_W-1:0]    sales
);

    localparam logic [CREDIT_W:0] LP_PRICE_X = (CREDIT_W + 1)'(PRICE);
    localparam logic [CNT_W-1:0]  LP_CNT_ONE = CNT_W'(1);

    state_e              r_state;
    logic                r_water;
    logic                r_change;
    logic                r_busy;
    logic [CNT_W-1:0]    r_sales;

    state_e              w_next_state;
    logic                w_coin_en;
    logic                w_sub;
    logic                w_dec;
    logic                w_accept;
    logic [CREDIT_W-1:0] w_credit;
    logic [CREDIT_W:0]   w_sum;
    logic                w_credit_nz;

    vend_credit_acc #(
        .CREDIT_W   (CREDIT_W),
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT),
        .VAL_ONE    (VAL_ONE),
        .VAL_TWO    (VAL_TWO),
        .VAL_FIVE   (VAL_FIVE)
    ) u_acc (
        .clk           (clk),
        .reset         (reset),
        .i_one         (ONE),
        .i_two         (TWO),
        .i_five        (FIVE),
        .i_coin_en     (w_coin_en),
        .i_sub_price   (w_sub),
        .i_dec         (w_dec),
        .o_credit      (w_credit),
        .o_sum         (w_sum),
        .o_accept      (w_accept),
        .o_coin_reject (coin_reject)
    );

    // Kept outside the next-state block: it feeds the accumulator, whose
    // accept flag feeds back into the next-state decision.
    assign w_coin_en   = (r_state == ST_IDLE) || ((r_state == ST_COLLECT) && !cancel);
    assign w_credit_nz = (w_credit != '0);

    always_comb begin
        w_next_state = r_state;
        w_sub        = 1'b0;
        w_dec        = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_COLLECT: begin
                if ((r_state == ST_COLLECT) && cancel) begin
                    // Refund starts immediately; COLLECT implies credit > 0.
                    w_next_state = ST_CHANGE;
                    w_dec        = 1'b1;
                end else if (w_accept) begin
                    if (w_sum >= LP_PRICE_X) begin
                        w_next_state = ST_VEND;
                        w_sub        = 1'b1;
                    end else begin
                        w_next_state = ST_COLLECT;
                    end
                end
            end
            ST_VEND: begin
                if (w_credit_nz) begin
                    w_next_state = ST_CHANGE;
                    w_dec        = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                // The pulse that took credit to zero has already been shown.
                if (w_credit_nz) begin
                    w_dec = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_water  <= 1'b0;
            r_change <= 1'b0;
            r_busy   <= 1'b0;
            r_sales  <= '0;
        end else begin
            r_state  <= w_next_state;
            r_water  <= (w_next_state == ST_VEND);
            r_change <= w_dec;
            r_busy   <= state_is_busy(w_next_state);
            if (w_sub && (r_sales != '1)) begin
                r_sales <= r_sales + LP_CNT_ONE;
            end
        end
    end

    assign water  = r_water;
    assign change = r_change;
    assign busy   = r_busy;
    assign credit = w_credit;
    assign sales  = r_sales;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// -----------------------------------------------------------------------------
// tb_vend_credit_fsm
// Scoreboard bench for vend_credit_fsm. The driver applies one input vector
// per cycle, runs the reference model and queues the expected outputs; the
// monitor pops one entry per cycle and compares against the DUT.
// The model tracks credit and sales as integers and represents a vend or
// refund as a planned list of future output cycles.
// -----------------------------------------------------------------------------
module tb_vend_credit_fsm;

    localparam int CREDIT_W   = 5;
    localparam int CNT_W      = 8;
    localparam int PRICE      = 3;
    localparam int MAX_CREDIT = 20;
    localparam int VAL_ONE    = 1;
    localparam int VAL_TWO    = 2;
    localparam int VAL_FIVE   = 5;
    localparam int SALES_MAX  = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                ONE = 1'b0;
    logic                TWO = 1'b0;
    logic                FIVE = 1'b0;
    logic                cancel = 1'b0;
    logic                water;
    logic                change;
    logic                coin_reject;
    logic                busy;
    logic [CREDIT_W-1:0] credit;
    logic [CNT_W-1:0]    sales;

    always #5 clk = ~clk;

    vend_credit_fsm #(
        .CREDIT_W   (CREDIT_W),
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT),
        .VAL_ONE    (VAL_ONE),
        .VAL_TWO    (VAL_TWO),
        .VAL_FIVE   (VAL_FIVE),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ONE         (ONE),
        .TWO         (TWO),
        .FIVE        (FIVE),
        .cancel      (cancel),
        .water       (water),
        .change      (change),
        .coin_reject (coin_reject),
        .busy        (busy),
        .credit      (credit),
        .sales       (sales)
    );

    // Output vector: {water, change, coin_reject, busy, credit[4:0], sales[7:0]}
    typedef logic [16:0] outv_t;

    typedef struct {
        string tag;
        outv_t val;
    } exp_t;

    typedef struct {
        bit water;
        bit change;
        int credit;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];

    int m_credit = 0;
    int m_sales  = 0;
    bit m_busy   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic outv_t pack(input bit w, input bit c, input bit r, input bit b,
                                   input int cr, input int s);
        logic [4:0] cr5;
        logic [7:0] s8;
        cr5 = 5'(cr);
        s8  = 8'(s);
        return {w, c, r, b, cr5, s8};
    endfunction

    task automatic check(input string tag, input outv_t act, input outv_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got water=%0b change=%0b rej=%0b busy=%0b credit=%0d sales=%0d, expected water=%0b change=%0b rej=%0b busy=%0b credit=%0d sales=%0d",
                     tag, $time, act[16], act[15], act[14], act[13], act[12:8], act[7:0],
                     exp[16], exp[15], exp[14], exp[13], exp[12:8], exp[7:0]);
        end
    endtask

    // Reference model: one call per clock edge, returns outputs after that edge.
    task automatic model_step(input bit rst, input bit one, input bit two, input bit five,
                              input bit can, output outv_t e);
        bit    rej;
        bit    w;
        bit    c;
        int    val;
        int    n;
        int    surplus;
        plan_t it;
        rej = 1'b0;
        w   = 1'b0;
        c   = 1'b0;
        n   = int'(one) + int'(two) + int'(five);
        if (rst) begin
            plan_q.delete();
            m_credit = 0;
            m_sales  = 0;
            m_busy   = 1'b0;
            e = pack(0, 0, 0, 0, 0, 0);
            return;
        end
        if (m_busy) begin
            rej = (n > 0);
        end else if (can && m_credit > 0) begin
            rej = (n > 0);
            for (int k = m_credit - 1; k >= 0; k--) plan_q.push_back('{1'b0, 1'b1, k});
        end else begin
            val = five ? VAL_FIVE : (two ? VAL_TWO : (one ? VAL_ONE : 0));
            if (val != 0 && m_credit + val <= MAX_CREDIT) begin
                rej = (n > 1);
                m_credit += val;
                if (m_credit >= PRICE) begin
                    if (m_sales < SALES_MAX) m_sales++;
                    surplus = m_credit - PRICE;
                    plan_q.push_back('{1'b1, 1'b0, surplus});
                    for (int k = surplus - 1; k >= 0; k--) plan_q.push_back('{1'b0, 1'b1, k});
                end
            end else begin
                rej = (n > 0);
            end
        end
        if (plan_q.size() > 0) begin
            it       = plan_q.pop_front();
            w        = it.water;
            c        = it.change;
            m_credit = it.credit;
            m_busy   = 1'b1;
        end else begin
            m_busy = 1'b0;
        end
        e = pack(w, c, rej, m_busy, m_credit, m_sales);
    endtask

    task automatic cycle(input string tag, input bit rst, input bit one, input bit two,
                         input bit five, input bit can);
        outv_t e;
        reset  = rst;
        ONE    = one;
        TWO    = two;
        FIVE   = five;
        cancel = can;
        model_step(rst, one, two, five, can, e);
        exp_q.push_back('{tag, e});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one output set per cycle, sampled on the falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check(x.tag, {water, change, coin_reject, busy, credit, sales}, x.val);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cycle("reset", 1, 0, 0, 0, 0);
        cycle("reset", 1, 0, 0, 0, 0);

        cycle("five_vend", 0, 0, 0, 1, 0);
        idle("five_change", 4);

        cycle("one_a", 0, 1, 0, 0, 0);
        cycle("one_b", 0, 1, 0, 0, 0);
        cycle("one_c_vend", 0, 1, 0, 0, 0);
        idle("one_after", 3);

        cycle("two_a", 0, 0, 1, 0, 0);
        cycle("two_b_vend", 0, 0, 1, 0, 0);
        idle("two_change", 4);

        cycle("cancel_one", 0, 1, 0, 0, 0);
        cycle("cancel_refund", 0, 0, 0, 0, 1);
        idle("cancel_after", 3);

        cycle("five_two_prio", 0, 0, 1, 1, 0);
        cycle("one_while_busy", 0, 1, 0, 0, 0);
        idle("prio_after", 4);

        cycle("cancel_two_one", 0, 1, 0, 0, 0);
        cycle("cancel_two_both", 0, 0, 1, 0, 1);
        idle("cancel_two_after", 3);

        cycle("cancel_idle_ign", 0, 0, 0, 0, 1);
        cycle("cancel_idle_coin", 0, 0, 1, 0, 1);
        idle("cancel_idle_after", 2);

        cycle("rst_mid_five", 0, 0, 0, 1, 0);
        idle("rst_mid_chg", 1);
        cycle("rst_mid_reset", 1, 0, 0, 0, 0);
        idle("rst_mid_after", 3);

        // Long run without reset drives sales into saturation.
        for (int i = 0; i < 3000; i++) begin
            cycle("rand_run", 0,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

        for (int i = 0; i < 1000; i++) begin
            cycle("rand_rst", ($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end
        idle("tail", 2);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
